// File: rtl/stonyman_frame_sequencer_pkg.sv
// stonyman_frame_sequencer_pkg: state encoding and size constants shared by the frame sequencer.
package stonyman_frame_sequencer_pkg;
    localparam int STATE_BITS       = 3;
    localparam int DEFAULT_PTR_BITS = 8;
    localparam int STONYMAN_SIZE    = 112;
    typedef enum logic [STATE_BITS-1:0] {
        IDLE, RST_ROW, RST_COL, CAPTURE, WAIT_ADC, INC_COL, INC_ROW, DONE
    } seq_state_t;
endpackage

// File: rtl/stonyman_pulse_gen.sv
// stonyman_pulse_gen: pin pulse timer, high for P cycles then low for P cycles, P = max(p, 1).
module stonyman_pulse_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] p,
    output logic       high,
    output logic       done
);
    logic [8:0] cnt, p_eff, last;
    // high is the level the pin must take in the following cycle, so the caller can register it
    always_comb begin
        p_eff = (p == 8'd0) ? 9'd1 : {1'b0, p};
        last  = {p_eff[7:0], 1'b0} - 9'd1;
        high  = start || (cnt + 9'd1 < p_eff);
        done  = cnt >= last;
    end
    always_ff @(posedge clk) begin
        if (reset || start)
            cnt <= '0;
        else if (!done)
            cnt <= cnt + 9'd1;
    end
endmodule

// File: rtl/stonyman_frame_sequencer.sv
// stonyman_frame_sequencer: walks the Stonyman row/column pointers and requests one ADC capture per pixel.
// Defining SEQ_TIMEOUT_EN adds the capture-done watchdog and the sticky timeout_err port.
module stonyman_frame_sequencer
    import stonyman_frame_sequencer_pkg::*;
#(
    parameter int PTR_BITS = DEFAULT_PTR_BITS
`ifdef SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic [PTR_BITS-1:0] row_count,
    input  logic [PTR_BITS-1:0] col_count,
    input  logic [7:0]          pulse_counts,
    input  logic                adc_capture_done,
    output logic                adc_capture_start,
    output logic                resv,
    output logic                incv,
    output logic                resp,
    output logic                incp,
    output logic [PTR_BITS-1:0] pixel_row,
    output logic [PTR_BITS-1:0] pixel_col,
    output logic                busy,
    output logic                frame_done
`ifdef SEQ_TIMEOUT_EN
    , output logic              timeout_err
`endif
);
    seq_state_t state, state_n;
    logic [PTR_BITS-1:0] row_last, col_last;
    logic [3:0] pin_sel;
    logic accept, pg_start, pg_high, pg_done, timeout_hit;

    stonyman_pulse_gen u_pulse (
        .clk   (clk),
        .reset (reset),
        .start (pg_start),
        .p     (pulse_counts),
        .high  (pg_high),
        .done  (pg_done)
    );

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES);
    logic [WD_BITS-1:0] wd;
    // frame_done lands TIMEOUT_CYCLES after the capture request cycle
    assign timeout_hit = state == WAIT_ADC && !adc_capture_done && wd == WD_BITS'(TIMEOUT_CYCLES - 2);
    always_ff @(posedge clk) begin
        if (reset) begin
            wd          <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd          <= (state == WAIT_ADC && state_n == WAIT_ADC) ? wd + WD_BITS'(1) : '0;
            timeout_err <= accept ? 1'b0 : (timeout_err || timeout_hit);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (frame_start) state_n = RST_ROW;
            RST_ROW:  if (pg_done) state_n = RST_COL;
            RST_COL:  if (pg_done) state_n = CAPTURE;
            INC_COL:  if (pg_done) state_n = CAPTURE;
            INC_ROW:  if (pg_done) state_n = RST_COL;
            CAPTURE:  state_n = WAIT_ADC;
            WAIT_ADC: if (adc_capture_done)
                          state_n = (pixel_col != col_last) ? INC_COL :
                                    (pixel_row != row_last) ? INC_ROW : DONE;
                      else if (timeout_hit)
                          state_n = DONE;
            DONE:     state_n = frame_start ? RST_ROW : IDLE;
        endcase
        accept   = frame_start && (state == IDLE || state == DONE);
        pin_sel  = {state_n == INC_COL, state_n == RST_COL, state_n == INC_ROW, state_n == RST_ROW};
        pg_start = |pin_sel && state_n != state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                    <= IDLE;
            {incp, resp, incv, resv} <= '0;
            adc_capture_start        <= 1'b0;
            busy                     <= 1'b0;
            frame_done               <= 1'b0;
            pixel_row                <= '0;
            pixel_col                <= '0;
            row_last                 <= '0;
            col_last                 <= '0;
        end else begin
            state                    <= state_n;
            {incp, resp, incv, resv} <= pin_sel & {4{pg_high}};
            adc_capture_start        <= state_n == CAPTURE;
            busy                     <= !(state_n == IDLE || state_n == DONE);
            frame_done               <= state_n == DONE;
            if (accept) begin
                row_last  <= (row_count == '0) ? '0 : row_count - PTR_BITS'(1);
                col_last  <= (col_count == '0) ? '0 : col_count - PTR_BITS'(1);
                pixel_row <= '0;
                pixel_col <= '0;
            end else if (state == WAIT_ADC && adc_capture_done) begin
                if (pixel_col != col_last)
                    pixel_col <= pixel_col + PTR_BITS'(1);
                else if (pixel_row != row_last) begin
                    pixel_row <= pixel_row + PTR_BITS'(1);
                    pixel_col <= '0;
                end
            end
        end
    end
endmodule
